arc4_encrypt: RTL and testbench



---
 rtl/arc4_encrypt.sv | 137 +++++++++++++
 tb/tb_arc4_encrypt.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 encrypt-side PRGA: copies length byte pt[0] to ct[0], then streams pt[1..L] xor keystream into ct.
// Six cycles per keystream byte; the first SKIP keystream bytes are generated (S is permuted) but dropped.
module arc4_encrypt #(
  parameter int SKIP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, LEN_WR, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_CT
  } state_t;

  localparam logic [9:0] SKIP_N = 10'(SKIP);

  state_t     state;
  logic [7:0] i, j, k, len, si, sj, ptbyte;
  logic [9:0] dcnt;
  logic       dropping;

  assign dropping = (dcnt < SKIP_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i      <= 8'd0;
      j      <= 8'd0;
      k      <= 8'd0;
      len    <= 8'd0;
      si     <= 8'd0;
      sj     <= 8'd0;
      ptbyte <= 8'd0;
      dcnt   <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            i     <= 8'd0;
            j     <= 8'd0;
            dcnt  <= 10'd0;
            k     <= 8'd1;
            state <= RD_LEN;
          end
        end
        RD_LEN: state <= LEN_WR;
        LEN_WR: begin
          len   <= pt_rddata;
          state <= (pt_rddata == 8'd0) ? IDLE : RD_SI;
        end
        RD_SI: begin
          i     <= i + 8'd1;
          state <= RD_SJ;
        end
        RD_SJ: begin
          si    <= s_rddata;
          j     <= j + s_rddata;
          state <= WR_SI;
        end
        WR_SI: begin
          sj    <= s_rddata;
          state <= WR_SJ;
        end
        WR_SJ: state <= RD_PAD;
        RD_PAD: begin
          ptbyte <= pt_rddata;
          state  <= WR_CT;
        end
        WR_CT: begin
          // k stops at len, so L=255 never wraps the ct address
          if (dropping) begin
            dcnt  <= dcnt + 10'd1;
            state <= RD_SI;
          end else if (k == len) begin
            state <= IDLE;
          end else begin
            k     <= k + 8'd1;
            state <= RD_SI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes are decoded from state; reads issued here return data in the next state.
  always_comb begin
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    pt_addr   = 8'd0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren   = 1'b0;
    case (state)
      IDLE: rdy = 1'b1;
      LEN_WR: begin
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      RD_SI: s_addr = i + 8'd1;
      RD_SJ: s_addr = j + s_rddata;
      WR_SI: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        pt_addr  = k;
      end
      RD_PAD: s_addr = si + sj;
      WR_CT: begin
        if (!dropping) begin
          ct_addr   = k;
          ct_wrdata = s_rddata ^ ptbyte;
          ct_wren   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: two instances (SKIP=0 and SKIP=2) on behavioural memories,
// checked against fixed vectors and a plain-arithmetic RC4 model.
module tb_arc4_encrypt;

  logic clk;
  logic rst;
  logic [1:0] en, rdy, s_wren, ct_wren;
  logic [1:0][7:0] s_addr, s_wrdata, s_rd, pt_addr, pt_rd, ct_addr, ct_wrdata;

  logic [7:0] s_mem  [2][256];
  logic [7:0] pt_mem [2][256];
  logic [7:0] ct_mem [2][256];
  int s_wcnt [2];
  int ct_wcnt[2];
  int ct_maxa[2];
  logic [7:0] ct_alog[2][4];

  logic       ld_en;
  int         ld_inst;
  logic [7:0] src_s [256];
  logic [7:0] src_pt[256];
  logic [7:0] ref_s [2][256];
  logic [7:0] exp_ct[256];
  logic [7:0] key[16];
  int klen;

  int chk_cnt;
  int pass_cnt;

  arc4_encrypt #(.SKIP(0)) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]),
    .s_addr(s_addr[0]), .s_rddata(s_rd[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .pt_addr(pt_addr[0]), .pt_rddata(pt_rd[0]),
    .ct_addr(ct_addr[0]), .ct_wrdata(ct_wrdata[0]), .ct_wren(ct_wren[0])
  );

  arc4_encrypt #(.SKIP(2)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]),
    .s_addr(s_addr[1]), .s_rddata(s_rd[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .pt_addr(pt_addr[1]), .pt_rddata(pt_rd[1]),
    .ct_addr(ct_addr[1]), .ct_wrdata(ct_wrdata[1]), .ct_wren(ct_wren[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories plus write monitors; a load copies src_s/src_pt and poisons ct.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      s_rd[n]  <= s_mem[n][s_addr[n]];
      pt_rd[n] <= pt_mem[n][pt_addr[n]];
      if (s_wren[n]) begin
        s_mem[n][s_addr[n]] <= s_wrdata[n];
        s_wcnt[n] <= s_wcnt[n] + 1;
      end
      if (ct_wren[n]) begin
        ct_mem[n][ct_addr[n]] <= ct_wrdata[n];
        if (ct_wcnt[n] < 4) ct_alog[n][ct_wcnt[n]] <= ct_addr[n];
        ct_wcnt[n] <= ct_wcnt[n] + 1;
        if (int'(ct_addr[n]) > ct_maxa[n]) ct_maxa[n] <= int'(ct_addr[n]);
      end
    end
    if (ld_en) begin
      for (int x = 0; x < 256; x++) begin
        s_mem[ld_inst][x]  <= src_s[x];
        pt_mem[ld_inst][x] <= src_pt[x];
        ct_mem[ld_inst][x] <= 8'hEE;
      end
      s_wcnt[ld_inst]  <= 0;
      ct_wcnt[ld_inst] <= 0;
      ct_maxa[ld_inst] <= -1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) src_s[x] = 8'(x);
  endtask

  task automatic ksa();
    int jj;
    logic [7:0] t;
    jj = 0;
    set_identity();
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(src_s[x]) + int'(key[x % klen])) % 256;
      t = src_s[x]; src_s[x] = src_s[jj]; src_s[jj] = t;
    end
  endtask

  task automatic load(input int n);
    for (int x = 0; x < 256; x++) ref_s[n][x] = src_s[x];
    @(negedge clk);
    ld_inst = n;
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Textbook RC4 PRGA on the model's copy of S; i and j restart at 0 for every run.
  task automatic model_run(input int n);
    int ii, jj, L, skip, idx;
    logic [7:0] t, pad;
    ii = 0; jj = 0;
    L = int'(src_pt[0]);
    skip = (n == 1) ? 2 : 0;
    exp_ct[0] = src_pt[0];
    if (L != 0) begin
      for (int it = 0; it < skip + L; it++) begin
        ii = (ii + 1) % 256;
        jj = (jj + int'(ref_s[n][ii])) % 256;
        t = ref_s[n][ii]; ref_s[n][ii] = ref_s[n][jj]; ref_s[n][jj] = t;
        pad = ref_s[n][(int'(ref_s[n][ii]) + int'(ref_s[n][jj])) % 256];
        if (it >= skip) begin
          idx = it - skip + 1;
          exp_ct[idx] = pad ^ src_pt[idx];
        end
      end
    end
  endtask

  task automatic run(input int n, output int lat);
    @(negedge clk);
    en[n] = 1'b1;
    @(negedge clk);
    en[n] = 1'b0;
    lat = 0;
    while (!rdy[n] && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic cmp_ct(input int n, input string nm);
    int bad;
    bad = 0;
    for (int x = 0; x <= int'(src_pt[0]); x++) if (ct_mem[n][x] !== exp_ct[x]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic cmp_s(input int n, input string nm);
    int bad;
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[n][x] !== ref_s[n][x]) bad++;
    chk(nm, bad, 0);
  endtask

  typedef struct {
    int inst;
    int sinit;
    int len;
    logic [7:0] pt[10];
    logic [7:0] ct[10];
    int lat;
    int ctw;
    int sw;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, lat, lat2, L, skip;
    chk_cnt = 0; pass_cnt = 0;
    rst = 1'b1; en = 2'b00; ld_en = 1'b0; ld_inst = 0; klen = 1;
    for (int x = 0; x < 16; x++) key[x] = 8'h00;
    for (int x = 0; x < 256; x++) begin src_s[x] = 8'h00; src_pt[x] = 8'h00; end

    vecs[0] = '{0, 0, 3,
      '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h03, 8'h02, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 20, 4, 6};
    vecs[1] = '{0, 1, 9,
      '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74},
      '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3}, 56, 10, 18};
    vecs[2] = '{0, 0, 0,
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1, 0};
    vecs[3] = '{1, 0, 1,
      '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 20, 2, 6};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("rst_rdy", int'(rdy[m]), 1);
      chk("rst_wren", int'({s_wren[m], ct_wren[m]}), 0);
      chk("rst_addr", int'(s_addr[m] | pt_addr[m] | ct_addr[m]), 0);
      chk("rst_wrdata", int'(s_wrdata[m] | ct_wrdata[m]), 0);
    end

    for (int v = 0; v < 4; v++) begin
      n = vecs[v].inst;
      if (vecs[v].sinit == 0) set_identity();
      else begin
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79; klen = 3;
        ksa();
      end
      for (int x = 0; x < 256; x++) src_pt[x] = (x < 10) ? vecs[v].pt[x] : 8'h00;
      load(n);
      model_run(n);
      run(n, lat);
      chk("vec_latency", lat, vecs[v].lat);
      for (int x = 0; x <= vecs[v].len; x++) chk("vec_ct", int'(ct_mem[n][x]), int'(vecs[v].ct[x]));
      chk("vec_ct_writes", ct_wcnt[n], vecs[v].ctw);
      chk("vec_s_writes", s_wcnt[n], vecs[v].sw);
      chk("vec_ct_addr0", int'(ct_alog[n][0]), 0);
      if (vecs[v].len >= 1) chk("vec_ct_addr1", int'(ct_alog[n][1]), 1);
      cmp_s(n, "vec_sbox");
    end

    // Reset during WR_SI of the second byte of a 9-byte run
    set_identity();
    src_pt[0] = 8'h09;
    for (int x = 1; x < 256; x++) src_pt[x] = 8'($urandom_range(0, 255));
    load(0);
    model_run(0);
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_in_wr_si", int'(s_wren[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", int'(rdy[0]), 1);
    chk("mid_rst_wren", int'({s_wren[0], ct_wren[0]}), 0);
    rst = 1'b0;
    chk("mid_ct0_kept", int'(ct_mem[0][0]), 9);
    chk("mid_ct1_kept", int'(ct_mem[0][1]), int'(exp_ct[1]));
    chk("mid_ct2_untouched", int'(ct_mem[0][2]), 8'hEE);

    set_identity();
    for (int x = 0; x < 256; x++) src_pt[x] = 8'h00;
    src_pt[0] = 8'h03;
    load(0);
    model_run(0);
    run(0, lat);
    chk("rerun_latency", lat, 20);
    chk("rerun_ct1", int'(ct_mem[0][1]), 8'h02);
    chk("rerun_ct2", int'(ct_mem[0][2]), 8'h05);
    chk("rerun_ct3", int'(ct_mem[0][3]), 8'h07);
    chk("rerun_s2", int'(s_mem[0][2]), 3);
    chk("rerun_s3", int'(s_mem[0][3]), 5);
    chk("rerun_s5", int'(s_mem[0][5]), 2);

    // en pulsed while busy must not start a second run
    load(0);
    model_run(0);
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    lat = 0;
    while (!rdy[0] && lat < 500) begin
      @(negedge clk);
      lat++;
      en[0] = (lat < 17) && (lat % 3 == 1);
    end
    en[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_latency", lat, 20);
    chk("busy_still_idle", int'(rdy[0]), 1);
    chk("busy_ct_writes", ct_wcnt[0], 4);
    cmp_ct(0, "busy_ct");

    // en held high: second run starts right after rdy returns and continues from permuted S
    load(0);
    model_run(0);
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!rdy[0] && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("held_latency1", lat, 20);
    cmp_ct(0, "held_ct_run1");
    @(negedge clk);
    chk("held_restart_busy", int'(rdy[0]), 0);
    chk("held_rd_len_addr", int'(pt_addr[0]), 0);
    en[0] = 1'b0;
    @(negedge clk);
    chk("held_len_rewrite", int'({ct_wren[0], ct_addr[0]}), 9'h100);
    model_run(0);
    lat2 = 1;
    while (!rdy[0] && lat2 < 500) begin
      @(negedge clk);
      lat2++;
    end
    chk("held_latency2", lat2, 20);
    cmp_ct(0, "held_ct_run2");
    cmp_s(0, "held_sbox");

    // Randomized runs on random KSA keys, including L=0 with drop and L=255
    for (int r = 0; r < 6; r++) begin
      n = r % 2;
      skip = (n == 1) ? 2 : 0;
      klen = $urandom_range(1, 16);
      for (int x = 0; x < 16; x++) key[x] = 8'($urandom_range(0, 255));
      ksa();
      L = (r == 3) ? 0 : (r == 4) ? 255 : $urandom_range(1, 24);
      src_pt[0] = 8'(L);
      for (int x = 1; x < 256; x++) src_pt[x] = 8'($urandom_range(0, 255));
      load(n);
      model_run(n);
      run(n, lat);
      chk("rand_latency", lat, (L == 0) ? 2 : 2 + 6 * (skip + L));
      cmp_ct(n, "rand_ct");
      cmp_s(n, "rand_sbox");
      chk("rand_ct_max_addr", ct_maxa[n], L);
      chk("rand_ct_writes", ct_wcnt[n], L + 1);
      chk("rand_s_writes", s_wcnt[n], (L == 0) ? 0 : 2 * (skip + L));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
